// File: rtl/d_cache_ctrl_if.sv
// ---------------------------------------------------------------------------
// d_cache_ctrl_if
// Bundles the CPU word port and the memory line-port control signals of the
// data cache. The shared 64-bit memory data bus stays a plain inout on the
// cache because it is tri-stated between the cache and the memory model.
//
//   cpu_read/cpu_write   word read / write request          (CPU -> cache)
//   cpu_address          word address                       (CPU -> cache)
//   cpu_wdata            write data                         (CPU -> cache)
//   cpu_rdata            read data                          (cache -> CPU)
//   cpu_ready            access completes this cycle        (cache -> CPU)
//   d_readM/d_writeM     memory line read / word write      (cache -> mem)
//   d_address            memory address                     (cache -> mem)
//
// master: CPU + memory side.  slave: the cache.
// ---------------------------------------------------------------------------
interface d_cache_ctrl_if #(
    parameter int WORD_SIZE = 16
);
    logic                 cpu_read;
    logic                 cpu_write;
    logic [WORD_SIZE-1:0] cpu_address;
    logic [WORD_SIZE-1:0] cpu_wdata;
    logic [WORD_SIZE-1:0] cpu_rdata;
    logic                 cpu_ready;
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata,
        input  cpu_rdata, cpu_ready, d_readM, d_writeM, d_address
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata,
        output cpu_rdata, cpu_ready, d_readM, d_writeM, d_address
    );
endinterface

// File: rtl/d_cache_ctrl.sv
// ---------------------------------------------------------------------------
// d_cache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache between a 16-bit
// CPU word port and a fixed-latency 64-bit line memory (no ready signal, so
// the cache counts MEM_LATENCY cycles itself).
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bus            d_cache_ctrl_if.slave: CPU request/response + memory control
//   d_data         64-bit memory data bus, driven only while d_writeM=1
//   hit_count      IDLE read hits (retry after a fill excluded), wraps
//   miss_count     read misses, wraps
// ---------------------------------------------------------------------------
module d_cache_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int LINE_SIZE   = 64,
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    d_cache_ctrl_if.slave        bus,
    inout  wire  [LINE_SIZE-1:0] d_data,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    localparam int WPL   = LINE_SIZE / WORD_SIZE;
    localparam int OFF_W = $clog2(WPL);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    // Control state
    logic [1:0]           state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 from_fetch_q, from_fetch_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic [15:0]          miss_cnt_q, miss_cnt_d;

    // Line storage; validity lives in valid_q so these need no reset
    logic [LINE_SIZE-1:0] data_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

    // Address split of the live CPU request and of the latched request
    logic [OFF_W-1:0] cur_off, q_off;
    logic [IDX_W-1:0] cur_idx, q_idx;
    logic [TAG_W-1:0] cur_tag, q_tag;
    logic             cur_hit, q_hit, lat_last;
    logic [LINE_SIZE-1:0] cur_line;

    assign cur_off = bus.cpu_address[OFF_W-1:0];
    assign cur_idx = bus.cpu_address[OFF_W +: IDX_W];
    assign cur_tag = bus.cpu_address[WORD_SIZE-1 -: TAG_W];
    assign q_off   = addr_q[OFF_W-1:0];
    assign q_idx   = addr_q[OFF_W +: IDX_W];
    assign q_tag   = addr_q[WORD_SIZE-1 -: TAG_W];

    assign cur_line = data_mem[cur_idx];
    assign cur_hit  = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);
    assign q_hit    = valid_q[q_idx] && (tag_mem[q_idx] == q_tag);
    assign lat_last = (lat_q == LAT_W'(MEM_LATENCY - 1));

    // Combinational outputs
    logic                 ready_c;
    logic [WORD_SIZE-1:0] rdata_c;
    logic                 read_m_c, write_m_c;
    logic [WORD_SIZE-1:0] daddr_c;
    logic                 fill_en, wr_en;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        from_fetch_d = 1'b0;
        valid_d      = valid_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        ready_c      = 1'b0;
        rdata_c      = '0;
        read_m_c     = 1'b0;
        write_m_c    = 1'b0;
        daddr_c      = '0;
        fill_en      = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Read wins over a simultaneous write
                if (bus.cpu_read) begin
                    if (cur_hit) begin
                        ready_c = 1'b1;
                        rdata_c = cur_line[int'(cur_off)*WORD_SIZE +: WORD_SIZE];
                        // The retry right after a fill is the same access
                        // that already counted as a miss
                        if (!from_fetch_q)
                            hit_cnt_d = hit_cnt_q + 16'd1;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                        addr_d     = bus.cpu_address;
                        lat_d      = '0;
                        state_d    = S_FETCH;
                    end
                end else if (bus.cpu_write) begin
                    addr_d  = bus.cpu_address;
                    wdata_d = bus.cpu_wdata;
                    lat_d   = '0;
                    state_d = S_WRITE;
                end
            end

            S_FETCH: begin
                read_m_c = 1'b1;
                daddr_c  = {q_tag, q_idx, {OFF_W{1'b0}}};
                if (lat_last) begin
                    fill_en        = 1'b1;
                    valid_d[q_idx] = 1'b1;
                    from_fetch_d   = 1'b1;
                    lat_d          = '0;
                    state_d        = S_IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            S_WRITE: begin
                write_m_c = 1'b1;
                daddr_c   = addr_q;
                if (lat_last) begin
                    ready_c = 1'b1;
                    // No allocate: only a resident line is updated
                    wr_en   = q_hit;
                    lat_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lat_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            from_fetch_q <= 1'b0;
            valid_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            from_fetch_q <= from_fetch_d;
            valid_q      <= valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // fill_en/wr_en are only raised outside reset (state_q is IDLE there)
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[q_idx] <= d_data;
            tag_mem[q_idx]  <= q_tag;
        end else if (wr_en) begin
            data_mem[q_idx][int'(q_off)*WORD_SIZE +: WORD_SIZE] <= wdata_q;
        end
    end

    assign bus.cpu_ready = ready_c;
    assign bus.cpu_rdata = rdata_c;
    assign bus.d_readM   = read_m_c;
    assign bus.d_writeM  = write_m_c;
    assign bus.d_address = daddr_c;
    assign d_data        = write_m_c ? {{(LINE_SIZE-WORD_SIZE){1'b0}}, wdata_q} : 'z;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule
